vga_stream_out: RTL and testbench
=================================

Name: vga_stream_out

Overview:
- Parametrised VGA/LCD raster output stage. Successor to the fixed 640x480, 16-bit VGA output of the pd_block system.
- Consumes a packetised pixel stream (one packet per frame, SOP on the first pixel) from the frame reader.
- Generates hsync, vsync and data-enable with programmable timing and polarity.
- Self-aligns to frame start, recovers from underflow/misalignment, and reports status for the software driver.

Parameters:
- PIXEL_W, 16, pixel bus width (RGB565 default)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, 1 = hsync active-high
- VS_POL, 0, 1 = vsync active-high
- BLANK_RGB, 0, colour driven on active pixels while not locked

Ports:
- clock  in  1  pixel clock
- sreset  in  1  synchronous active-high reset
- enable  in  1  raster run enable
- snk_data  in  PIXEL_W  pixel
- snk_valid  in  1  pixel valid
- snk_sop  in  1  first pixel of frame
- snk_ready  out  1  pixel accepted when valid&ready
- vga_rgb  out  PIXEL_W  pixel out
- vga_valid  out  1  data enable (active region)
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- locked  out  1  stream aligned to raster
- vblank_pulse  out  1  one-cycle pulse at start of vertical blanking
- underflow_count  out  16  saturating error count (underflow + misalignment)

Behaviour:
- Reset is synchronous on clock while sreset=1 and dominates all other inputs. Reset values:
  - vga_rgb=0, vga_valid=0, snk_ready=0, locked=0, vblank_pulse=0, underflow_count=0
  - vga_hsync=~HS_POL, vga_vsync=~VS_POL
  - counters h=v=0, state IDLE
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters:
  - h runs 0..H_TOTAL-1 and wraps to 0.
  - v increments when h wraps and wraps after V_TOTAL-1.
  - Active region: h<H_ACTIVE and v<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on v, for whole lines.
- Latency: all outputs are registered one cycle after the counter position they describe, and all are mutually aligned. A pixel accepted at position (h,v) appears on vga_rgb in the same cycle as that position's vga_valid.
- vblank_pulse=1 for the single output cycle corresponding to (h=0, v=V_ACTIVE).
- States:
  - IDLE: enable=0. Counters held at 0, syncs inactive, vga_valid=0, snk_ready=0. enable=1 -> SEEK; counting starts the next cycle.
  - SEEK: raster runs, vga_rgb=BLANK_RGB when active.
    - snk_ready=1 while head beat is not SOP, so the stream is flushed.
    - A valid SOP beat is held (ready=0).
    - When the counter is at (0,0) and valid&sop: accept it -> LOCKED, locked=1.
  - LOCKED: snk_ready=1 exactly at active positions.
    - Active position, valid, sop=(h==0&&v==0): pixel output.
    - Active position, valid=0 (underflow): output BLANK_RGB, count+1, -> SEEK, locked=0.
    - SOP at a non-(0,0) position, or non-SOP at (0,0) (misalignment): beat not consumed, output BLANK_RGB, count+1, -> SEEK.
- underflow_count saturates at 0xFFFF and clears only on reset.
- enable falling at any point -> IDLE next cycle:
  - Counters cleared, outputs return to their reset values, except underflow_count, which is retained.
  - Partial-frame data stays in the source. It is discarded by SEEK on re-enable.
- Error and (0,0) lock evaluated in the same cycle: the error check uses the current state only, so a lock cannot occur in the cycle an error is flagged.

Decomposition:
- vga_out_pkg holds:
  - State enum (IDLE, SEEK, LOCKED)
  - Function computing H_TOTAL/V_TOTAL
  - Counter-width function clog2
- Sub-module vga_timing_gen holds the h/v counters, sync/active/vblank decode and run input. vga_stream_out holds the FSM, sink handshake, output registers and counter.

Test Plan:
All scenarios use small timing: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1. Totals are 8x6 = 48 cycles/frame.
- Reset and timing:
  - Stimulus: hold sreset 3 cycles, then enable=1, no source.
  - Required: all outputs at reset values during reset. hsync low exactly for h=5,6 of every line; vsync low for line v=4; vga_valid on 12 cycles/frame; rgb=BLANK_RGB; vblank_pulse once per 48 cycles.
- Lock:
  - Stimulus: source presents 2 junk beats, then a 12-pixel frame with SOP on the first beat (values 1..12), always valid.
  - Required: junk consumed in SEEK. Lock at next (0,0); vga_rgb shows 1..12 on active cycles; locked=1.
- Underflow:
  - Stimulus: while locked, drop valid at pixel 6.
  - Required: BLANK_RGB from pixel 6, count=1, locked=0, relock on next frame's SOP at (0,0).
- Misalignment:
  - Stimulus: SOP arrives at pixel 3.
  - Required: beat not consumed, count+1, SEEK, then lock at the next (0,0) with that SOP beat.
- Enable drop:
  - Stimulus: enable=0 mid-line at h=2, v=1.
  - Required: next cycle syncs inactive, vga_valid=0, snk_ready=0, count retained. Re-enable starts raster at (0,0).
- Saturation and reset:
  - Stimulus: force 65537 errors, then assert sreset mid-frame.
  - Required: count holds 0xFFFF; sreset clears everything on the next edge.

Source files
------------

// File: rtl/vga_stream_out_pkg.sv
// Shared types and elaboration-time helpers for the VGA stream output stage.
package vga_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    LOCKED
  } state_t;

  function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(x)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vga_stream_out_if.sv
// Pixel stream handshake between the frame reader (master) and the raster output (slave).
interface vga_stream_out_if #(
  parameter int unsigned PIXEL_W = 16
);
  logic [PIXEL_W-1:0] snk_data;
  logic               snk_valid;
  logic               snk_sop;
  logic               snk_ready;

  modport master (output snk_data, output snk_valid, output snk_sop, input snk_ready);
  modport slave  (input snk_data, input snk_valid, input snk_sop, output snk_ready);
endinterface

// File: rtl/vga_stream_out_timing.sv
// Raster position counters and combinational decode of the current position.
module vga_timing_gen
  import vga_out_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic clock,
  input  logic sreset,
  input  logic run,
  output logic active,
  output logic hs_act,
  output logic vs_act,
  output logic vblank_start,
  output logic at_origin
);

  localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  // One spare code so sync end positions equal to the total still fit.
  localparam int unsigned HW = clog2(H_TOTAL + 1);
  localparam int unsigned VW = clog2(V_TOTAL + 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_ff @(posedge clock) begin
    if (sreset || !run) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    active       = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    hs_act       = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_act       = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
    vblank_start = (h == '0) && (v == VW'(V_ACTIVE));
    at_origin    = (h == '0) && (v == '0);
  end

endmodule

// File: rtl/vga_stream_out.sv
// Raster output stage: aligns a packetised pixel stream to the raster and drives
// registered RGB, data-enable and sync outputs, reporting lock and error status.
module vga_stream_out
  import vga_out_pkg::*;
#(
  parameter int unsigned        PIXEL_W   = 16,
  parameter int unsigned        H_ACTIVE  = 640,
  parameter int unsigned        H_FP      = 16,
  parameter int unsigned        H_SYNC    = 96,
  parameter int unsigned        H_BP      = 48,
  parameter int unsigned        V_ACTIVE  = 480,
  parameter int unsigned        V_FP      = 10,
  parameter int unsigned        V_SYNC    = 2,
  parameter int unsigned        V_BP      = 33,
  parameter bit                 HS_POL    = 1'b0,
  parameter bit                 VS_POL    = 1'b0,
  parameter logic [PIXEL_W-1:0] BLANK_RGB = '0
) (
  input  logic               clock,
  input  logic               sreset,
  input  logic               enable,
  vga_stream_out_if.slave    snk,
  output logic [PIXEL_W-1:0] vga_rgb,
  output logic               vga_valid,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               locked,
  output logic               vblank_pulse,
  output logic [15:0]        underflow_count
);

  state_t      state;
  logic [15:0] err_count;
  logic        run;
  logic        active, hs_act, vs_act, vblank_start, at_origin;
  logic        ready;
  logic        lock_now;
  logic        err_now;

  assign run             = enable && (state != IDLE);
  assign underflow_count = err_count;
  assign snk.snk_ready   = ready;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clock        (clock),
    .sreset       (sreset),
    .run          (run),
    .active       (active),
    .hs_act       (hs_act),
    .vs_act       (vs_act),
    .vblank_start (vblank_start),
    .at_origin    (at_origin)
  );

  // Errors are judged only in LOCKED and lock only in SEEK, so both can never fire together.
  always_comb begin
    lock_now = (state == SEEK) && at_origin && snk.snk_valid && snk.snk_sop;
    err_now  = (state == LOCKED) && active &&
               (!snk.snk_valid || (snk.snk_sop != at_origin));
    ready    = 1'b0;
    if (!sreset && enable) begin
      case (state)
        SEEK:    ready = !(snk.snk_valid && snk.snk_sop) || at_origin;
        LOCKED:  ready = active && !(snk.snk_valid && (snk.snk_sop != at_origin));
        default: ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (sreset) begin
      state        <= IDLE;
      vga_rgb      <= '0;
      vga_valid    <= 1'b0;
      vga_hsync    <= ~HS_POL;
      vga_vsync    <= ~VS_POL;
      locked       <= 1'b0;
      vblank_pulse <= 1'b0;
      err_count    <= '0;
    end else if (!enable || state == IDLE) begin
      state        <= enable ? SEEK : IDLE;
      vga_rgb      <= '0;
      vga_valid    <= 1'b0;
      vga_hsync    <= ~HS_POL;
      vga_vsync    <= ~VS_POL;
      locked       <= 1'b0;
      vblank_pulse <= 1'b0;
    end else begin
      vga_hsync    <= hs_act ? HS_POL : ~HS_POL;
      vga_vsync    <= vs_act ? VS_POL : ~VS_POL;
      vga_valid    <= active;
      vblank_pulse <= vblank_start;
      vga_rgb      <= '0;
      case (state)
        SEEK: begin
          if (active) vga_rgb <= BLANK_RGB;
          if (lock_now) begin
            vga_rgb <= snk.snk_data;
            locked  <= 1'b1;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (err_now) begin
            vga_rgb <= BLANK_RGB;
            locked  <= 1'b0;
            state   <= SEEK;
            if (err_count != '1) err_count <= err_count + 16'd1;
          end else if (active) begin
            vga_rgb <= snk.snk_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on an 8x6 raster: timing, lock, underflow,
// misalignment, enable drop, error-count saturation and mid-frame reset.
module tb_vga_stream_out;

  localparam logic [15:0] BLANK = 16'h00F0;

  logic        clock;
  logic        sreset;
  logic        enable;
  logic [15:0] vga_rgb;
  logic        vga_valid, vga_hsync, vga_vsync, locked, vblank_pulse;
  logic [15:0] underflow_count;

  vga_stream_out_if #(.PIXEL_W(16)) s ();

  vga_stream_out #(
    .PIXEL_W   (16),
    .H_ACTIVE  (4),
    .H_FP      (1),
    .H_SYNC    (2),
    .H_BP      (1),
    .V_ACTIVE  (3),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1),
    .HS_POL    (1'b0),
    .VS_POL    (1'b0),
    .BLANK_RGB (BLANK)
  ) dut (
    .clock           (clock),
    .sreset          (sreset),
    .enable          (enable),
    .snk             (s.slave),
    .vga_rgb         (vga_rgb),
    .vga_valid       (vga_valid),
    .vga_hsync       (vga_hsync),
    .vga_vsync       (vga_vsync),
    .locked          (locked),
    .vblank_pulse    (vblank_pulse),
    .underflow_count (underflow_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int p = -1;
  int last_f = 0;
  int idx = 0;
  bit src_on = 1'b0;
  logic [15:0] q_data[$];
  bit          q_sop[$];
  bit          q_bub[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (pos %0d)", tag, obs, exp, p);
    end
  endtask

  function automatic bit act(input int f);
    return ((f % 8) < 4) && ((f / 8) < 3);
  endfunction

  task automatic push(input logic [15:0] d, input bit sop, input bit bub);
    q_data.push_back(d);
    q_sop.push_back(sop);
    q_bub.push_back(bub);
  endtask

  task automatic drive_src();
    if (src_on && idx < q_data.size()) begin
      s.snk_valid = !q_bub[idx];
      s.snk_data  = q_data[idx];
      s.snk_sop   = q_sop[idx];
    end else begin
      s.snk_valid = 1'b0;
      s.snk_data  = '0;
      s.snk_sop   = 1'b0;
    end
  endtask

  task automatic check_idle_outputs();
    chk("idle_rgb", vga_rgb, 0);
    chk("idle_valid", vga_valid, 0);
    chk("idle_hsync", vga_hsync, 1);
    chk("idle_vsync", vga_vsync, 1);
    chk("idle_locked", locked, 0);
    chk("idle_vblank", vblank_pulse, 0);
  endtask

  task automatic check_reset();
    check_idle_outputs();
    chk("reset_count", underflow_count, 0);
    chk("reset_ready", s.snk_ready, 0);
  endtask

  // One clock: consume the head beat if it was taken (or was a bubble), then check raster timing.
  task automatic cyc();
    bit acc, bub;
    int h, v;
    #1;
    acc = s.snk_valid && s.snk_ready;
    bub = src_on && (idx < q_data.size()) && q_bub[idx];
    @(posedge clock);
    #1;
    if (acc || bub) idx++;
    drive_src();
    #1;
    if (sreset) begin
      p = -1;
    end else if (!enable || p < 0) begin
      p = enable ? 0 : -1;
      check_idle_outputs();
    end else begin
      last_f = p % 48;
      p++;
      h = last_f % 8;
      v = last_f / 8;
      chk("hsync", vga_hsync, (h == 5 || h == 6) ? 0 : 1);
      chk("vsync", vga_vsync, (v == 4) ? 0 : 1);
      chk("valid", vga_valid, act(last_f));
      chk("vblank", vblank_pulse, (h == 0 && v == 3));
      if (!act(last_f)) chk("rgb_outside_active", vga_rgb, 0);
    end
  endtask

  initial begin
    int vcnt, vbc;
    logic [15:0] k;

    sreset = 1'b1;
    enable = 1'b0;
    drive_src();

    // Reset held three cycles.
    repeat (3) begin
      cyc();
      check_reset();
    end

    // Free-running raster with no source.
    sreset = 1'b0;
    enable = 1'b1;
    cyc();
    vcnt = 0;
    vbc  = 0;
    for (int i = 0; i < 90; i++) begin
      cyc();
      if (act(last_f)) chk("rgb_seek_blank", vga_rgb, BLANK);
      chk("locked_seek", locked, 0);
      if (i < 48) begin
        vcnt += int'(vga_valid);
        vbc  += int'(vblank_pulse);
      end
    end
    chk("valid_per_frame", vcnt, 12);
    chk("vblank_per_frame", vbc, 1);

    push(16'h0111, 0, 0);
    push(16'h0222, 0, 0);
    for (int i = 1; i <= 12; i++) push(16'(i), i == 1, 0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 6) push(16'h0000, 0, 1);
      push(16'(32 + i), i == 1, 0);
    end
    push(16'h0031, 1, 0);
    push(16'h0032, 0, 0);
    for (int i = 1; i <= 12; i++) push(16'(64 + i), i == 1, 0);
    for (int i = 1; i <= 3; i++) begin
      push(16'(80 + i), 1, 0);
      push(16'h0000, 0, 1);
    end

    // Lock: junk flushed, SOP held until the origin.
    src_on = 1'b1;
    drive_src();
    #1;
    chk("ready_flush_junk", s.snk_ready, 1);
    cyc();
    cyc();
    chk("ready_hold_sop", s.snk_ready, 0);
    repeat (4) cyc();
    chk("ready_lock_origin", s.snk_ready, 1);
    k = 16'h0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (act(last_f)) begin
        k++;
        chk("rgb_frame_a", vga_rgb, k);
      end
      chk("locked_a", locked, 1);
      chk("count_a", underflow_count, 0);
      chk("ready_a", s.snk_ready, act(p % 48));
    end

    // Underflow at pixel 6, relock on the next frame's SOP.
    k = 16'h20;
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (act(last_f)) begin
        if (last_f < 9) begin
          k++;
          chk("rgb_frame_b", vga_rgb, k);
        end else begin
          chk("rgb_underflow_blank", vga_rgb, BLANK);
        end
      end
      chk("locked_b", locked, last_f < 9);
      chk("count_b", underflow_count, (last_f >= 9) ? 1 : 0);
      if (p >= 161 && p < 192) chk("ready_hold_c", s.snk_ready, 0);
      if (p == 192) chk("ready_relock_c", s.snk_ready, 1);
    end

    // Misaligned SOP at pixel 3.
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (act(last_f)) begin
        if (last_f == 0) chk("rgb_c1", vga_rgb, 16'h0031);
        else if (last_f == 1) chk("rgb_c2", vga_rgb, 16'h0032);
        else chk("rgb_misalign_blank", vga_rgb, BLANK);
      end
      chk("locked_c", locked, last_f < 2);
      chk("count_c", underflow_count, (last_f >= 2) ? 2 : 1);
      if (p == 194) chk("ready_misalign", s.snk_ready, 0);
      if (p == 240) chk("ready_lock_d", s.snk_ready, 1);
    end

    // Frame D until enable drops at h=2, v=1.
    k = 16'h40;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (act(last_f)) begin
        k++;
        chk("rgb_frame_d", vga_rgb, k);
      end
      chk("locked_d", locked, 1);
    end
    enable = 1'b0;
    #1;
    chk("ready_enable_drop", s.snk_ready, 0);
    repeat (4) begin
      cyc();
      chk("count_retained", underflow_count, 2);
      chk("ready_idle", s.snk_ready, 0);
    end

    // Re-enable: raster restarts at the origin in SEEK.
    enable = 1'b1;
    cyc();
    for (int i = 0; i < 47; i++) begin
      cyc();
      if (act(last_f)) chk("rgb_reenable_blank", vga_rgb, BLANK);
      if (i == 0) chk("reenable_origin_valid", vga_valid, 1);
      chk("locked_reenable", locked, 0);
      chk("count_reenable", underflow_count, 2);
    end

    // Preload the error count near its ceiling, then cause three more errors.
    force dut.err_count = 16'hFFFD;
    #1;
    release dut.err_count;
    cyc();
    chk("ready_lock_e", s.snk_ready, 1);
    k = 16'h50;
    while (p < 146) begin
      cyc();
      if (last_f == 0) begin
        k++;
        chk("rgb_lock_e", vga_rgb, k);
        chk("locked_e", locked, 1);
      end
      if (p == 50) chk("count_fffe", underflow_count, 16'hFFFE);
      if (p == 98) chk("count_ffff", underflow_count, 16'hFFFF);
    end
    chk("count_saturated", underflow_count, 16'hFFFF);
    chk("locked_after_sat", locked, 0);

    // Mid-frame reset clears everything, including the error count.
    sreset = 1'b1;
    cyc();
    check_reset();
    sreset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
